// File: rtl/des_key_schedule_pkg.sv
// Shared DES key-schedule constants, subtypes and half-key rotate helpers.
// All bit vectors use the codebase's [1:N] numbering, where bit 1 is the MSB.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;

  typedef logic [1:28] half_t;
  typedef logic [1:56] cd_t;
  typedef logic [1:48] subkey_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int unsigned SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int unsigned PC2_IDX [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Round numbers outside 1..16 map to a single-bit shift; they are never used.
  function automatic logic shift_is2(input logic [4:0] n);
    shift_is2 = (n >= 5'd1 && n <= 5'd16) ? (SHIFTS[n] == 2) : 1'b0;
  endfunction

  function automatic half_t rotl(input half_t h, input logic two);
    rotl = two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
  endfunction

  function automatic half_t rotr(input half_t h, input logic two);
    rotr = two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Handshake bundle between the key-schedule engine and its upstream/consumer.
interface des_key_schedule_if;
  import des_pkg::*;

  logic       start;
  logic       decrypt;
  cd_t        key_cd;
  logic       subkey_ready;
  logic       busy;
  logic       subkey_valid;
  subkey_t    subkey;
  logic [3:0] round;
  logic       done;

  modport master (
    output start, decrypt, key_cd, subkey_ready,
    input  busy, subkey_valid, subkey, round, done
  );

  modport slave (
    input  start, decrypt, key_cd, subkey_ready,
    output busy, subkey_valid, subkey, round, done
  );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// PC-2 permutation: combinational selection of 48 of the 56 C/D bits.
module pc2
  import des_pkg::*;
(
  input  cd_t     cd,
  output subkey_t subkey
);
  assign subkey[1]  = cd[PC2_IDX[1]];
  assign subkey[2]  = cd[PC2_IDX[2]];
  assign subkey[3]  = cd[PC2_IDX[3]];
  assign subkey[4]  = cd[PC2_IDX[4]];
  assign subkey[5]  = cd[PC2_IDX[5]];
  assign subkey[6]  = cd[PC2_IDX[6]];
  assign subkey[7]  = cd[PC2_IDX[7]];
  assign subkey[8]  = cd[PC2_IDX[8]];
  assign subkey[9]  = cd[PC2_IDX[9]];
  assign subkey[10] = cd[PC2_IDX[10]];
  assign subkey[11] = cd[PC2_IDX[11]];
  assign subkey[12] = cd[PC2_IDX[12]];
  assign subkey[13] = cd[PC2_IDX[13]];
  assign subkey[14] = cd[PC2_IDX[14]];
  assign subkey[15] = cd[PC2_IDX[15]];
  assign subkey[16] = cd[PC2_IDX[16]];
  assign subkey[17] = cd[PC2_IDX[17]];
  assign subkey[18] = cd[PC2_IDX[18]];
  assign subkey[19] = cd[PC2_IDX[19]];
  assign subkey[20] = cd[PC2_IDX[20]];
  assign subkey[21] = cd[PC2_IDX[21]];
  assign subkey[22] = cd[PC2_IDX[22]];
  assign subkey[23] = cd[PC2_IDX[23]];
  assign subkey[24] = cd[PC2_IDX[24]];
  assign subkey[25] = cd[PC2_IDX[25]];
  assign subkey[26] = cd[PC2_IDX[26]];
  assign subkey[27] = cd[PC2_IDX[27]];
  assign subkey[28] = cd[PC2_IDX[28]];
  assign subkey[29] = cd[PC2_IDX[29]];
  assign subkey[30] = cd[PC2_IDX[30]];
  assign subkey[31] = cd[PC2_IDX[31]];
  assign subkey[32] = cd[PC2_IDX[32]];
  assign subkey[33] = cd[PC2_IDX[33]];
  assign subkey[34] = cd[PC2_IDX[34]];
  assign subkey[35] = cd[PC2_IDX[35]];
  assign subkey[36] = cd[PC2_IDX[36]];
  assign subkey[37] = cd[PC2_IDX[37]];
  assign subkey[38] = cd[PC2_IDX[38]];
  assign subkey[39] = cd[PC2_IDX[39]];
  assign subkey[40] = cd[PC2_IDX[40]];
  assign subkey[41] = cd[PC2_IDX[41]];
  assign subkey[42] = cd[PC2_IDX[42]];
  assign subkey[43] = cd[PC2_IDX[43]];
  assign subkey[44] = cd[PC2_IDX[44]];
  assign subkey[45] = cd[PC2_IDX[45]];
  assign subkey[46] = cd[PC2_IDX[46]];
  assign subkey[47] = cd[PC2_IDX[47]];
  assign subkey[48] = cd[PC2_IDX[48]];
endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: rotates C/D in place each round and emits
// PC-2(C,D) over valid/ready, in K1..K16 or K16..K1 order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  des_key_schedule_if.slave  bus
);
  state_t     state, state_n;
  half_t      c, c_n, d, d_n;
  logic [3:0] idx, idx_n;
  logic       dec, dec_n;
  logic       two;
  subkey_t    pk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      c     <= '0;
      d     <= '0;
      idx   <= '0;
      dec   <= 1'b0;
    end else begin
      state <= state_n;
      c     <= c_n;
      d     <= d_n;
      idx   <= idx_n;
      dec   <= dec_n;
    end
  end

  // idx holds step-1; decrypt walks backwards, so it undoes SHIFTS[16-idx].
  always_comb begin
    state_n = state;
    c_n     = c;
    d_n     = d;
    idx_n   = idx;
    dec_n   = dec;
    two     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_RUN;
          idx_n   = '0;
          dec_n   = bus.decrypt;
          if (bus.decrypt) begin
            c_n = bus.key_cd[1:28];
            d_n = bus.key_cd[29:56];
          end else begin
            two = shift_is2(5'd1);
            c_n = rotl(bus.key_cd[1:28], two);
            d_n = rotl(bus.key_cd[29:56], two);
          end
        end
      end
      ST_RUN: begin
        if (bus.subkey_ready) begin
          if (idx == 4'(DES_ROUNDS - 1)) begin
            state_n = ST_DONE;
          end else begin
            idx_n = idx + 4'd1;
            if (dec) begin
              two = shift_is2(5'd16 - {1'b0, idx});
              c_n = rotr(c, two);
              d_n = rotr(d, two);
            end else begin
              two = shift_is2({1'b0, idx} + 5'd2);
              c_n = rotl(c, two);
              d_n = rotl(d, two);
            end
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (pk)
  );

  assign bus.busy         = (state == ST_RUN);
  assign bus.subkey_valid = (state == ST_RUN);
  assign bus.done         = (state == ST_DONE);
  assign bus.subkey       = (state == ST_RUN) ? pk : '0;
  assign bus.round        = (state != ST_RUN) ? '0 :
                            dec ? (4'(DES_ROUNDS - 1) - idx) : idx;
endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, randomized keys and
// backpressure against a direct key-schedule model, plus reset/start corners.
module tb_des_key_schedule;
  logic clk;
  logic rst;

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned sh   [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int unsigned pc2t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic [47:0] exp_k [16];
  logic [3:0]  exp_r [16];
  logic [47:0] obs_first, obs_last;
  logic [3:0]  obs_fr, obs_lr;

  typedef struct {
    logic [55:0] key;
    bit          dec;
    logic [47:0] first;
    logic [3:0]  fr;
    logic [47:0] last;
    logic [3:0]  lr;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] h, input int unsigned n);
    logic [55:0] dbl;
    dbl = {h, h} << n;
    return dbl[55:28];
  endfunction

  // Schedule straight from the definition: K_i = PC2(C_i,D_i), C_i = C_{i-1} <<< SHIFTS[i].
  function automatic void model(input logic [55:0] key, input bit dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k [16];
    c = key[55:28];
    d = key[27:0];
    for (int i = 0; i < 16; i++) begin
      c  = rotl28(c, sh[i]);
      d  = rotl28(d, sh[i]);
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[i][47-j] = cd[56-pc2t[j]];
    end
    for (int i = 0; i < 16; i++) begin
      exp_k[i] = dec ? k[15-i] : k[i];
      exp_r[i] = dec ? 4'(15 - i) : 4'(i);
    end
  endfunction

  // Caller must be at a negedge with the DUT in IDLE.
  task automatic run(input logic [55:0] key, input bit dec, input bit rnd,
                     input bit noise, input int unsigned rst_after);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    bit stalled = 0;
    bit r;
    logic [47:0] held = '0;
    model(key, dec);
    bus.start   = 1'b1;
    bus.decrypt = dec;
    bus.key_cd  = key;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (k < 16) begin
      if (cyc > 300) begin
        total++;
        bad++;
        $display("FAIL timeout got=%0d handshakes want=16", k);
        break;
      end
      if (rst_after != 0 && k == rst_after) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_valid", 64'(bus.subkey_valid), 0);
        chk("rst_subkey", 64'(bus.subkey), 0);
        chk("rst_round", 64'(bus.round), 0);
        chk("rst_done", 64'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_nodone", 64'(bus.done), 0);
        chk("rst_idle", 64'(bus.busy), 0);
        return;
      end
      chk("valid", 64'(bus.subkey_valid), 1);
      chk("busy", 64'(bus.busy), 1);
      chk("subkey", 64'(bus.subkey), 64'(exp_k[k]));
      chk("round", 64'(bus.round), 64'(exp_r[k]));
      if (stalled) chk("hold", 64'(bus.subkey), 64'(held));
      if (k == 0)  begin obs_first = bus.subkey; obs_fr = bus.round; end
      if (k == 15) begin obs_last  = bus.subkey; obs_lr = bus.round; end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.subkey_ready = r;
      if (r) begin
        k++;
        stalled = 0;
      end else begin
        stalls++;
        stalled = 1;
        held = bus.subkey;
      end
      if (noise) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.key_cd  = 56'({$urandom, $urandom});
        bus.decrypt = ~dec;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done", 64'(bus.done), 1);
    chk("done_time", 64'(cyc), 64'(17 + stalls));
    chk("done_valid", 64'(bus.subkey_valid), 0);
    if (noise) begin
      bus.start  = 1'b1;
      bus.key_cd = 56'({$urandom, $urandom});
    end
    @(negedge clk);
    chk("after_done", 64'(bus.done), 0);
    chk("idle_busy", 64'(bus.busy), 0);
    chk("idle_valid", 64'(bus.subkey_valid), 0);
    bus.start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{56'hF0CCAAF556678F, 1'b0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
    tbl[1] = '{56'hF0CCAAF556678F, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};
    tbl[2] = '{56'hFFFFFFFFFFFFFF, 1'b0, 48'hFFFFFFFFFFFF, 4'd0,  48'hFFFFFFFFFFFF, 4'd15};
    tbl[3] = '{56'h00000000000000, 1'b1, 48'h000000000000, 4'd15, 48'h000000000000, 4'd0};

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.decrypt      = 1'b0;
    bus.key_cd       = '0;
    bus.subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_valid", 64'(bus.subkey_valid), 0);
    chk("reset_done", 64'(bus.done), 0);
    chk("reset_subkey", 64'(bus.subkey), 0);
    chk("reset_round", 64'(bus.round), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid0", 64'(bus.subkey_valid), 0);

    for (int i = 0; i < 4; i++) begin
      run(tbl[i].key, tbl[i].dec, 0, 0, 0);
      chk("tbl_first", 64'(obs_first), 64'(tbl[i].first));
      chk("tbl_first_round", 64'(obs_fr), 64'(tbl[i].fr));
      chk("tbl_last", 64'(obs_last), 64'(tbl[i].last));
      chk("tbl_last_round", 64'(obs_lr), 64'(tbl[i].lr));
    end

    // Start noise during RUN and the done cycle, then a back-to-back start.
    run(56'hF0CCAAF556678F, 0, 0, 1, 0);
    run(56'hF0CCAAF556678F, 1, 1, 0, 0);
    chk("b2b_first", 64'(obs_first), 64'h0000CB3D8B0E17F5);

    // Reset after the 5th handshake, then a clean schedule.
    run(56'({$urandom, $urandom}), 0, 0, 0, 5);
    run(56'hF0CCAAF556678F, 0, 0, 0, 0);
    chk("post_rst_k1", 64'(obs_first), 64'h00001B02EFFC7072);
    chk("post_rst_round", 64'(obs_fr), 0);

    for (int i = 0; i < 20; i++) begin
      run(56'({$urandom, $urandom}), 1'($urandom_range(0, 1)), 1,
          1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule engine that sits directly downstream of the PC-1 permutation. It takes the 56-bit permuted key (C0‖D0), performs the 16 per-round circular shifts, and applies PC-2 to emit one 48-bit subkey per round to the round datapath over a valid/ready handshake. Encrypt order emits K1..K16 and decrypt order emits K16..K1, with no precomputed key storage.

## Interface
Parameters: none. All constants live in the shared package.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new schedule; sampled only in IDLE
- decrypt  in  1  order select, sampled with start: 0 = K1..K16, 1 = K16..K1
- key_cd  in  [1:56]  PC-1 output; [1:28] = C0, [29:56] = D0; sampled with start
- subkey_ready  in  1  consumer accepts the current subkey
- busy  out  1  schedule in progress
- subkey_valid  out  1  subkey/round are valid
- subkey  out  [1:48]  PC-2(C,D) for the current round; bit 1 is MSB, matching the codebase's [1:N] DES bit numbering
- round  out  4  index of the emitted subkey, 1..16 encoded 0..15; always the true K index (decrypt counts 15 down to 0)
- done  out  1  one-cycle pulse after the 16th handshake

## Operation
- States:
  - IDLE: busy=0, subkey_valid=0.
  - RUN: busy=1, subkey_valid=1.
  - DONE: one cycle, done=1, then IDLE.
- Shift table SHIFTS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total 28, so C16=C0 and D16=D0.
- Encrypt:
  - On start, C/D ← key_cd rotated left by SHIFTS[1]; step=1.
  - On each handshake with step<16: C/D rotate left by SHIFTS[step+1].
- Decrypt:
  - On start, C/D ← key_cd unrotated, since K16 uses C16=C0; step=1.
  - On each handshake with step<16: C/D rotate right by SHIFTS[17−step].
- Rotation: C and D rotate independently, each within its own 28 bits. A left rotate by 1 moves bit 1 to bit 28.
- subkey = PC2({C,D}), combinational from the C/D registers.
- Handshake (valid & ready at a rising edge):
  - On the 16th handshake, go to DONE.
  - While valid & !ready, C, D, step, subkey and round hold stable.
- start during RUN or DONE is ignored. key_cd and decrypt are don't-care outside the start cycle.

## Timing
- Reset values: busy=0, subkey_valid=0, done=0, subkey=0, round=0, state=IDLE, C=D=0. Force subkey to 0 whenever not valid.
- start sampled high at edge E0 → subkey_valid=1 with the first subkey in the cycle after E0 (latency 1).
- With subkey_ready held at 1, one subkey per cycle: 16 consecutive valid cycles, then done=1 for one cycle, then IDLE.
- start→first subkey: 1 cycle. start→done: 17 cycles minimum.
- Back-to-back: start may be asserted during the done cycle but is ignored. It is accepted in the following IDLE cycle, so the minimum start-to-start spacing is 18 cycles.
- rst mid-RUN: on the next edge, all outputs and state return to reset values. No done pulse is produced.
- ready low for N cycles extends RUN by exactly N cycles. No subkey is skipped or duplicated.

## Structure
- Shared package des_pkg holds:
  - SHIFTS[1..16] constant.
  - PC-2 index table.
  - DES_ROUNDS = 16.
  - Subtypes for the 28-bit half key, 56-bit CD and 48-bit subkey.
- Sub-module pc2: purely combinational [1:56] → [1:48] permutation, written in the same per-bit assign form as the codebase's PC-1.
- The top holds the FSM, step counter, C/D registers and rotate muxes (rotate by 1 or 2, left or right).

## Test plan
- FIPS example, encrypt: key_cd=56'hF0CCAAF556678F, decrypt=0, ready=1 → first subkey=48'h1B02EFFC7072 with round=0. 16th subkey=48'hCB3D8B0E17F5 with round=15. done pulses 17 cycles after start.
- Same key, decrypt=1 → first subkey=48'hCB3D8B0E17F5 with round=15. Last subkey=48'h1B02EFFC7072 with round=0. The full sequence is the exact reverse of the encrypt run.
- Backpressure: random ready with ~50% duty → subkey stays stable while valid & !ready. Exactly 16 handshakes occur and the sequence matches the reference model.
- start pulses during RUN and during the done cycle → ignored; the current sequence is unaffected. start in the following IDLE cycle launches a new schedule.
- rst asserted after the 5th handshake → next cycle busy=0, valid=0, subkey=0, round=0, no done pulse. A fresh start then yields K1 correctly.
- key_cd all-ones and 56'h0 → every subkey is all-ones and all-zero respectively. C/D wrap-around (bit 1 ↔ bit 28) is checked by a bench model over random keys.
